// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry,
// loader FSM state encodings and big-endian byte extraction.
package imem_pkg;

    localparam int DEF_MEM_WIDTH  = 8;
    localparam int DEF_MEM_DEPTH  = 1024;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_t;

    // Byte 0 is the most significant byte, so it lands at the lowest address.
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Writer side of the byte-wide instruction memory: takes 32-bit words from a
// valid/ready stream and writes each one as four big-endian byte writes.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 word_valid,
    input  logic [31:0]          word_data,
    input  logic                 word_last,
    output logic                 word_ready,
    output logic                 wr_en,
    output logic [31:0]          wr_addr,
    output logic [MEM_WIDTH-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [31:0]          word_count
);

    localparam logic [31:0] BASE      = 32'(BASE_ADDR);
    localparam logic [32:0] DEPTH_LIM = 33'(MEM_DEPTH);
    localparam logic [31:0] STEP      = 32'(BYTES_PER_WORD);

    loader_state_t        state_reg, state_next;
    logic [31:0]          ptr_reg, ptr_next;
    logic [1:0]           byte_idx_reg, byte_idx_next;
    logic [31:0]          word_reg, word_next;
    logic                 last_reg, last_next;
    logic [31:0]          count_reg, count_next;
    logic                 overflow_reg, overflow_next;

    logic                 word_ready_reg, word_ready_next;
    logic                 wr_en_reg, wr_en_next;
    logic [31:0]          wr_addr_reg, wr_addr_next;
    logic [MEM_WIDTH-1:0] wr_data_reg, wr_data_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;

    logic                 handshake;

    assign handshake = word_valid && word_ready_reg;

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        byte_idx_next = byte_idx_reg;
        word_next     = word_reg;
        last_next     = last_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_ACCEPT;
                    ptr_next      = BASE;
                    count_next    = '0;
                    overflow_next = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (handshake) begin
                    // 33-bit compare so a pointer near 2^32 cannot wrap past the check.
                    if ({1'b0, ptr_reg} + 33'd4 > DEPTH_LIM) begin
                        overflow_next = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        word_next     = word_data;
                        last_next     = word_last;
                        byte_idx_next = 2'd0;
                        state_next    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (byte_idx_reg == 2'd3) begin
                    byte_idx_next = 2'd0;
                    ptr_next      = ptr_reg + STEP;
                    count_next    = count_reg + 32'd1;
                    state_next    = last_reg ? ST_DONE : ST_ACCEPT;
                end else begin
                    byte_idx_next = byte_idx_reg + 2'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they line up with state_reg.
        word_ready_next = (state_next == ST_ACCEPT);
        busy_next       = (state_next == ST_ACCEPT) || (state_next == ST_WRITE);
        done_next       = (state_next == ST_DONE);
        wr_en_next      = (state_next == ST_WRITE);
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        if (state_next == ST_WRITE) begin
            wr_addr_next = ptr_next + {30'd0, byte_idx_next};
            wr_data_next = MEM_WIDTH'(get_byte(word_next, byte_idx_next));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= BASE;
            byte_idx_reg   <= 2'd0;
            word_reg       <= '0;
            last_reg       <= 1'b0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            word_ready_reg <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            byte_idx_reg   <= byte_idx_next;
            word_reg       <= word_next;
            last_reg       <= last_next;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            word_ready_reg <= word_ready_next;
            wr_en_reg      <= wr_en_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign word_ready = word_ready_reg;
    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign overflow   = overflow_reg;
    assign word_count = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: three instances (default, MEM_DEPTH=8, BASE_ADDR=16)
// with a byte-write log and a small memory model behind the default instance.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_s      [3];
    logic        word_valid_s [3];
    logic [31:0] word_data_s  [3];
    logic        word_last_s  [3];
    logic        word_ready_s [3];
    logic        wr_en_s      [3];
    logic [31:0] wr_addr_s    [3];
    logic [7:0]  wr_data_s    [3];
    logic        busy_s       [3];
    logic        done_s       [3];
    logic        overflow_s   [3];
    logic [31:0] word_count_s [3];

    int errors = 0;
    int checks = 0;

    logic [39:0] wlog0[$];
    logic [39:0] wlog1[$];
    logic [39:0] wlog2[$];
    int          done_cnt [3] = '{0, 0, 0};
    logic [7:0]  mem0 [0:1023];

    always #5 clk = ~clk;

    imem_loader #(.MEM_WIDTH(8), .MEM_DEPTH(1024), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .word_valid(word_valid_s[0]),
        .word_data(word_data_s[0]), .word_last(word_last_s[0]), .word_ready(word_ready_s[0]),
        .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]), .wr_data(wr_data_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .overflow(overflow_s[0]), .word_count(word_count_s[0])
    );

    imem_loader #(.MEM_WIDTH(8), .MEM_DEPTH(8), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .word_valid(word_valid_s[1]),
        .word_data(word_data_s[1]), .word_last(word_last_s[1]), .word_ready(word_ready_s[1]),
        .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]), .wr_data(wr_data_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .overflow(overflow_s[1]), .word_count(word_count_s[1])
    );

    imem_loader #(.MEM_WIDTH(8), .MEM_DEPTH(1024), .BASE_ADDR(16)) dut2 (
        .clk(clk), .rst(rst), .start(start_s[2]), .word_valid(word_valid_s[2]),
        .word_data(word_data_s[2]), .word_last(word_last_s[2]), .word_ready(word_ready_s[2]),
        .wr_en(wr_en_s[2]), .wr_addr(wr_addr_s[2]), .wr_data(wr_data_s[2]), .busy(busy_s[2]),
        .done(done_s[2]), .overflow(overflow_s[2]), .word_count(word_count_s[2])
    );

    // Byte writes are committed at the clock edge where wr_en is high.
    always @(posedge clk) begin
        if (wr_en_s[0] === 1'b1) begin
            wlog0.push_back({wr_addr_s[0], wr_data_s[0]});
            if (wr_addr_s[0] < 32'd1024) mem0[wr_addr_s[0][9:0]] <= wr_data_s[0];
        end
        if (wr_en_s[1] === 1'b1) wlog1.push_back({wr_addr_s[1], wr_data_s[1]});
        if (wr_en_s[2] === 1'b1) wlog2.push_back({wr_addr_s[2], wr_data_s[2]});
        for (int k = 0; k < 3; k++)
            if (done_s[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start_s[k] = 1'b1;
        tick();
        start_s[k] = 1'b0;
    endtask

    // Present a word, wait (bounded) for ready, and return one cycle after the handshake edge.
    task automatic send_word(input int k, input logic [31:0] d, input logic last);
        int n = 0;
        word_valid_s[k] = 1'b1;
        word_data_s[k]  = d;
        word_last_s[k]  = last;
        while (word_ready_s[k] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL handshake_wait inst=%0d word=%h ready=%b required=1", k, d, word_ready_s[k]);
        end
        tick();
        word_valid_s[k] = 1'b0;
        word_data_s[k]  = $urandom;
        word_last_s[k]  = 1'b0;
        $display("inst=%0d word %h last=%b accepted", k, d, last);
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        while (done_s[k] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL done_wait inst=%0d done=%b required=1", k, done_s[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({word_ready_s[k], wr_en_s[k], busy_s[k], done_s[k], overflow_s[k]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_flags inst=%0d got=%b required=00000", k,
                         {word_ready_s[k], wr_en_s[k], busy_s[k], done_s[k], overflow_s[k]});
            end
            checks++;
            if (word_count_s[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_count inst=%0d got=%0d required=0", k, word_count_s[k]);
            end
            checks++;
            if (wr_addr_s[k] !== 32'd0 || wr_data_s[k] !== 8'd0) begin
                errors++;
                $display("FAIL reset_wr inst=%0d addr=%h data=%h required=0/0", k, wr_addr_s[k], wr_data_s[k]);
            end
        end
        rst = 1'b0;
        tick();
        $display("reset released");
    endtask

    task automatic test_load_two();
        logic [39:0] exp_log [8];
        logic [39:0] got;
        int base = wlog0.size();
        int dc   = done_cnt[0];
        exp_log = '{{32'd0, 8'h8C}, {32'd1, 8'h08}, {32'd2, 8'h00}, {32'd3, 8'h04},
                    {32'd4, 8'h01}, {32'd5, 8'h09}, {32'd6, 8'h50}, {32'd7, 8'h20}};
        pulse_start(0);
        checks++;
        if (busy_s[0] !== 1'b1 || word_ready_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL start_accept busy=%b ready=%b required=1/1", busy_s[0], word_ready_s[0]);
        end
        send_word(0, 32'h8C080004, 1'b0);
        checks++;
        if (wr_en_s[0] !== 1'b1 || word_ready_s[0] !== 1'b0 || wr_addr_s[0] !== 32'd0 || wr_data_s[0] !== 8'h8C) begin
            errors++;
            $display("FAIL first_byte wr_en=%b ready=%b addr=%h data=%h required=1/0/0/8c",
                     wr_en_s[0], word_ready_s[0], wr_addr_s[0], wr_data_s[0]);
        end
        tick(); tick(); tick();
        checks++;
        if (wr_addr_s[0] !== 32'd3 || wr_data_s[0] !== 8'h04) begin
            errors++;
            $display("FAIL fourth_byte addr=%h data=%h required=3/04", wr_addr_s[0], wr_data_s[0]);
        end
        tick();
        checks++;
        if (wr_en_s[0] !== 1'b0 || word_ready_s[0] !== 1'b1 || word_count_s[0] !== 32'd1) begin
            errors++;
            $display("FAIL ready_after_word wr_en=%b ready=%b count=%0d required=0/1/1",
                     wr_en_s[0], word_ready_s[0], word_count_s[0]);
        end
        send_word(0, 32'h01095020, 1'b1);
        tick(); tick(); tick(); tick();
        checks++;
        if (done_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || word_count_s[0] !== 32'd2) begin
            errors++;
            $display("FAIL done_timing done=%b busy=%b count=%0d required=1/0/2",
                     done_s[0], busy_s[0], word_count_s[0]);
        end
        tick();
        checks++;
        if (done_s[0] !== 1'b0 || done_cnt[0] - dc !== 1) begin
            errors++;
            $display("FAIL done_pulse done=%b pulses=%0d required=0/1", done_s[0], done_cnt[0] - dc);
        end
        for (int i = 0; i < 8; i++) begin
            got = (base + i < wlog0.size()) ? wlog0[base + i] : 40'hx;
            checks++;
            if (got !== exp_log[i]) begin
                errors++;
                $display("FAIL load_two_byte%0d got=%h required=%h", i, got, exp_log[i]);
            end
        end
        $display("load_two: %0d byte writes logged", wlog0.size() - base);
    endtask

    task automatic test_roundtrip();
        logic [31:0] instr;
        instr = {mem0[4], mem0[5], mem0[6], mem0[7]};
        checks++;
        if (instr !== 32'h01095020) begin
            errors++;
            $display("FAIL roundtrip_addr4 got=%h required=01095020", instr);
        end
        instr = {mem0[0], mem0[1], mem0[2], mem0[3]};
        checks++;
        if (instr !== 32'h8C080004) begin
            errors++;
            $display("FAIL roundtrip_addr0 got=%h required=8c080004", instr);
        end
        $display("roundtrip: fetched instruction at 4 = %h", {mem0[4], mem0[5], mem0[6], mem0[7]});
    endtask

    task automatic test_overflow();
        logic [39:0] exp_log [8];
        logic [39:0] got;
        int base = wlog1.size();
        int dc   = done_cnt[1];
        exp_log = '{{32'd0, 8'h11}, {32'd1, 8'h22}, {32'd2, 8'h33}, {32'd3, 8'h44},
                    {32'd4, 8'h55}, {32'd5, 8'h66}, {32'd6, 8'h77}, {32'd7, 8'h88}};
        pulse_start(1);
        send_word(1, 32'h11223344, 1'b0);
        send_word(1, 32'h55667788, 1'b0);
        send_word(1, 32'h99AABBCC, 1'b0);
        checks++;
        if (overflow_s[1] !== 1'b1 || busy_s[1] !== 1'b0 || word_ready_s[1] !== 1'b0 || wr_en_s[1] !== 1'b0) begin
            errors++;
            $display("FAIL overflow_abort ovf=%b busy=%b ready=%b wr_en=%b required=1/0/0/0",
                     overflow_s[1], busy_s[1], word_ready_s[1], wr_en_s[1]);
        end
        tick(); tick(); tick();
        checks++;
        if (word_count_s[1] !== 32'd2 || overflow_s[1] !== 1'b1 || done_cnt[1] - dc !== 0) begin
            errors++;
            $display("FAIL overflow_state count=%0d ovf=%b dones=%0d required=2/1/0",
                     word_count_s[1], overflow_s[1], done_cnt[1] - dc);
        end
        checks++;
        if (wlog1.size() - base !== 8) begin
            errors++;
            $display("FAIL overflow_nwrites got=%0d required=8", wlog1.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            got = (base + i < wlog1.size()) ? wlog1[base + i] : 40'hx;
            checks++;
            if (got !== exp_log[i]) begin
                errors++;
                $display("FAIL overflow_byte%0d got=%h required=%h", i, got, exp_log[i]);
            end
        end
        pulse_start(1);
        checks++;
        if (overflow_s[1] !== 1'b0 || busy_s[1] !== 1'b1 || word_count_s[1] !== 32'd0) begin
            errors++;
            $display("FAIL restart_clears ovf=%b busy=%b count=%0d required=0/1/0",
                     overflow_s[1], busy_s[1], word_count_s[1]);
        end
        $display("overflow: session aborted after %0d words", 2);
    endtask

    task automatic test_stall_restart();
        logic [39:0] exp_log [8];
        logic [39:0] got;
        logic        saw_wr = 1'b0;
        logic        ready_ok = 1'b1;
        int base = wlog0.size();
        exp_log = '{{32'd0, 8'hA1}, {32'd1, 8'hB2}, {32'd2, 8'hC3}, {32'd3, 8'hD4},
                    {32'd4, 8'h0F}, {32'd5, 8'h1E}, {32'd6, 8'h2D}, {32'd7, 8'h3C}};
        pulse_start(0);
        for (int i = 0; i < 4; i++) begin
            word_valid_s[0] = 1'b0;
            word_data_s[0]  = $urandom;
            if (wr_en_s[0] !== 1'b0) saw_wr = 1'b1;
            if (word_ready_s[0] !== 1'b1) ready_ok = 1'b0;
            tick();
        end
        checks++;
        if (saw_wr !== 1'b0 || ready_ok !== 1'b1) begin
            errors++;
            $display("FAIL stall_idle saw_wr=%b ready_held=%b required=0/1", saw_wr, ready_ok);
        end
        send_word(0, 32'hA1B2C3D4, 1'b0);
        word_valid_s[0] = 1'b1;
        word_data_s[0]  = 32'hFFFFFFFF;
        pulse_start(0);
        checks++;
        if (word_ready_s[0] !== 1'b0 || busy_s[0] !== 1'b1 || wr_en_s[0] !== 1'b1 || wr_addr_s[0] !== 32'd1) begin
            errors++;
            $display("FAIL start_in_write ready=%b busy=%b wr_en=%b addr=%h required=0/1/1/1",
                     word_ready_s[0], busy_s[0], wr_en_s[0], wr_addr_s[0]);
        end
        send_word(0, 32'h0F1E2D3C, 1'b1);
        wait_done(0);
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        checks++;
        if (busy_s[0] !== 1'b0 || word_ready_s[0] !== 1'b0 || word_count_s[0] !== 32'd2) begin
            errors++;
            $display("FAIL start_in_done busy=%b ready=%b count=%0d required=0/0/2",
                     busy_s[0], word_ready_s[0], word_count_s[0]);
        end
        for (int i = 0; i < 8; i++) begin
            got = (base + i < wlog0.size()) ? wlog0[base + i] : 40'hx;
            checks++;
            if (got !== exp_log[i]) begin
                errors++;
                $display("FAIL stall_byte%0d got=%h required=%h", i, got, exp_log[i]);
            end
        end
        $display("stall_restart: %0d byte writes logged", wlog0.size() - base);
    endtask

    task automatic test_reset_mid_write();
        logic [39:0] exp_log [4];
        logic [39:0] got;
        int base;
        int dc = done_cnt[0];
        exp_log = '{{32'd0, 8'h12}, {32'd1, 8'h34}, {32'd2, 8'h56}, {32'd3, 8'h78}};
        pulse_start(0);
        send_word(0, 32'hCAFEF00D, 1'b1);
        tick();
        tick();
        checks++;
        if (wr_en_s[0] !== 1'b1 || wr_addr_s[0] !== 32'd2 || wr_data_s[0] !== 8'hF0) begin
            errors++;
            $display("FAIL pre_reset_byte2 wr_en=%b addr=%h data=%h required=1/2/f0",
                     wr_en_s[0], wr_addr_s[0], wr_data_s[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wr_en_s[0], busy_s[0], word_ready_s[0], done_s[0], overflow_s[0]} !== 5'b0 ||
            word_count_s[0] !== 32'd0 || wr_addr_s[0] !== 32'd0 || wr_data_s[0] !== 8'd0) begin
            errors++;
            $display("FAIL async_reset flags=%b count=%0d addr=%h data=%h required=0",
                     {wr_en_s[0], busy_s[0], word_ready_s[0], done_s[0], overflow_s[0]},
                     word_count_s[0], wr_addr_s[0], wr_data_s[0]);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (done_cnt[0] - dc !== 0) begin
            errors++;
            $display("FAIL reset_no_done pulses=%0d required=0", done_cnt[0] - dc);
        end
        base = wlog0.size();
        pulse_start(0);
        send_word(0, 32'h12345678, 1'b1);
        wait_done(0);
        checks++;
        if (word_count_s[0] !== 32'd1) begin
            errors++;
            $display("FAIL restart_count got=%0d required=1", word_count_s[0]);
        end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < wlog0.size()) ? wlog0[base + i] : 40'hx;
            checks++;
            if (got !== exp_log[i]) begin
                errors++;
                $display("FAIL restart_byte%0d got=%h required=%h", i, got, exp_log[i]);
            end
        end
        $display("reset_mid_write: restart logged %0d writes", wlog0.size() - base);
    endtask

    task automatic test_base_addr();
        logic [39:0] exp_log [4];
        logic [39:0] got;
        int base = wlog2.size();
        exp_log = '{{32'd16, 8'hDE}, {32'd17, 8'hAD}, {32'd18, 8'hBE}, {32'd19, 8'hEF}};
        pulse_start(2);
        send_word(2, 32'hDEADBEEF, 1'b1);
        wait_done(2);
        checks++;
        if (word_count_s[2] !== 32'd1 || wlog2.size() - base !== 4) begin
            errors++;
            $display("FAIL base_summary count=%0d writes=%0d required=1/4", word_count_s[2], wlog2.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < wlog2.size()) ? wlog2[base + i] : 40'hx;
            checks++;
            if (got !== exp_log[i]) begin
                errors++;
                $display("FAIL base_byte%0d got=%h required=%h", i, got, exp_log[i]);
            end
        end
        $display("base_addr: DEADBEEF written from address 16");
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k]      = 1'b0;
            word_valid_s[k] = 1'b0;
            word_data_s[k]  = 32'd0;
            word_last_s[k]  = 1'b0;
        end
        test_reset();
        test_load_two();
        test_roundtrip();
        test_overflow();
        test_stall_restart();
        test_reset_mid_write();
        test_base_addr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
